// File: rtl/layer_arb_pkg.sv
// layer_arb_pkg: shared types and sizing helpers for the layer share arbiter
package layer_arb_pkg;
  typedef logic req_id_t;
  typedef enum logic {IDLE, SEND} arb_state_t;
  localparam int N_DEF = 8;
  localparam int M_DEF = 6;
  localparam int N_CNT_W = $clog2(N_DEF);
  localparam int M_CNT_W = $clog2(M_DEF);
  function automatic int cnt_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/layer_tag_fifo.sv
// layer_tag_fifo: 1-bit requester-ID FIFO tracking vectors in flight through the layer
// ports: clk, reset (async, active-high), push/din write, pop read, head = oldest tag, full/empty flags
module layer_tag_fifo
  import layer_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    push,
  input  req_id_t din,
  input  logic    pop,
  output req_id_t head,
  output logic    full,
  output logic    empty
);
  localparam int AW = $clog2(DEPTH);
  logic [DEPTH-1:0] mem;
  logic [AW:0] wp, rp;
  // extra pointer MSB distinguishes full from empty when the index bits match
  assign head = mem[rp[AW-1:0]];
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      mem <= '0;
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) begin
        mem[wp[AW-1:0]] <= din;
        wp <= wp + 1'b1;
      end
      if (pop) rp <= rp + 1'b1;
    end
endmodule

// File: rtl/layer_share_arb.sv
// layer_share_arb: time-shares one layer datapath between two requesters at whole-vector granularity
// ports: s0_/s1_ upstream word streams, m0_/m1_ result streams, l_* to/from the shared layer, clk, reset (async, active-high)
module layer_share_arb
  import layer_arb_pkg::*;
#(
  parameter int M = 6,
  parameter int N = 8,
  parameter int T = 16,
  parameter int TAG_DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         s0_valid,
  output logic         s0_ready,
  input  logic [T-1:0] s0_data,
  input  logic         s1_valid,
  output logic         s1_ready,
  input  logic [T-1:0] s1_data,
  output logic         m0_valid,
  input  logic         m0_ready,
  output logic [T-1:0] m0_data,
  output logic         m1_valid,
  input  logic         m1_ready,
  output logic [T-1:0] m1_data,
  output logic         l_s_valid,
  input  logic         l_s_ready,
  output logic [T-1:0] l_data_in,
  input  logic         l_m_valid,
  output logic         l_m_ready,
  input  logic [T-1:0] l_data_out
);
  localparam int IW = cnt_w(N);
  localparam int OW = cnt_w(M);
  localparam logic [IW-1:0] N_LAST = IW'(N - 1);
  localparam logic [OW-1:0] M_LAST = OW'(M - 1);
  arb_state_t state;
  req_id_t grant, prio, head, g;
  logic [IW-1:0] in_cnt;
  logic [OW-1:0] out_cnt;
  logic full, empty, push, pop, send, in_last, l_s_hs, l_m_hs;
  // contested IDLE goes to prio; otherwise s1_valid alone selects requester 1
  assign g = (s0_valid && s1_valid) ? prio : s1_valid;
  assign push = (state == IDLE) && !full && (s0_valid || s1_valid);
  assign send = state == SEND;
  assign l_s_valid = send && (grant ? s1_valid : s0_valid);
  assign l_data_in = grant ? s1_data : s0_data;
  assign s0_ready = send && !grant && l_s_ready;
  assign s1_ready = send && grant && l_s_ready;
  assign l_s_hs = l_s_valid && l_s_ready;
  assign in_last = in_cnt == N_LAST;
  // results are steered by the oldest outstanding tag since the layer is in-order
  assign m0_valid = !empty && !head && l_m_valid;
  assign m1_valid = !empty && head && l_m_valid;
  assign m0_data = l_data_out;
  assign m1_data = l_data_out;
  assign l_m_ready = !empty && (head ? m1_ready : m0_ready);
  assign l_m_hs = l_m_valid && l_m_ready;
  assign pop = l_m_hs && (out_cnt == M_LAST);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      grant <= 1'b0;
      prio <= 1'b0;
      in_cnt <= '0;
    end else if (state == IDLE) begin
      if (push) begin
        grant <= g;
        state <= SEND;
      end
    end else if (l_s_hs) begin
      in_cnt <= in_last ? '0 : in_cnt + 1'b1;
      if (in_last) begin
        prio <= ~grant;
        state <= IDLE;
      end
    end
  always_ff @(posedge clk or posedge reset)
    if (reset) out_cnt <= '0;
    else if (l_m_hs) out_cnt <= pop ? '0 : out_cnt + 1'b1;
  layer_tag_fifo #(.DEPTH(TAG_DEPTH)) u_tag (
    .clk(clk),
    .reset(reset),
    .push(push),
    .din(g),
    .pop(pop),
    .head(head),
    .full(full),
    .empty(empty)
  );
endmodule

// File: tb/tb_layer_share_arb.sv
// tb_layer_share_arb: scoreboard bench for layer_share_arb with a behavioural in-order layer
`timescale 1ns/1ps
module tb_layer_share_arb;
  localparam int M = 6;
  localparam int N = 8;
  localparam int T = 16;
  localparam int TD = 4;
  typedef logic [T-1:0] vec_t [N];
  logic clk = 1'b0;
  logic reset;
  logic s0_valid, s0_ready, s1_valid, s1_ready;
  logic [T-1:0] s0_data, s1_data;
  logic m0_valid, m0_ready, m1_valid, m1_ready;
  logic [T-1:0] m0_data, m1_data;
  logic l_s_valid, l_s_ready, l_m_valid, l_m_ready;
  logic [T-1:0] l_data_in, l_data_out;
  always #5 clk = ~clk;
  layer_share_arb #(.M(M), .N(N), .T(T), .TAG_DEPTH(TD)) dut (
    .clk(clk), .reset(reset),
    .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_data(s0_data),
    .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_data(s1_data),
    .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_data(m0_data),
    .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_data(m1_data),
    .l_s_valid(l_s_valid), .l_s_ready(l_s_ready), .l_data_in(l_data_in),
    .l_m_valid(l_m_valid), .l_m_ready(l_m_ready), .l_data_out(l_data_out)
  );
  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int rdy_pct [2];
  int ocnt [2];
  int icnt [2];
  int lrdy, lvld;
  bit forbid1;
  int glog [$];
  logic [T-1:0] expq0 [$];
  logic [T-1:0] expq1 [$];
  logic [T-1:0] lq [$];
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  function automatic logic [T-1:0] lfn(input vec_t v, input int j);
    logic [T-1:0] s = '0;
    for (int i = 0; i < N; i++) s += v[i] * T'(i + j + 1);
    return s;
  endfunction
  initial begin
    vec_t acc;
    int lcnt = 0;
    logic ihs, ohs;
    logic [T-1:0] d;
    l_s_ready = 1'b0;
    l_m_valid = 1'b0;
    l_data_out = '0;
    forever begin
      @(negedge clk);
      ihs = l_s_valid && l_s_ready;
      ohs = l_m_valid && l_m_ready;
      d = l_data_in;
      @(posedge clk);
      #1;
      if (reset) begin
        lq.delete();
        lcnt = 0;
      end else begin
        if (ohs) void'(lq.pop_front());
        if (ihs) begin
          acc[lcnt] = d;
          lcnt++;
          if (lcnt == N) begin
            for (int j = 0; j < M; j++) lq.push_back(lfn(acc, j));
            lcnt = 0;
          end
        end
      end
      l_s_ready = !reset && ($urandom_range(99) < lrdy);
      l_m_valid = !reset && (lq.size() > 0) && ($urandom_range(99) < lvld);
      l_data_out = lq.size() > 0 ? lq[0] : '0;
    end
  end
  task automatic consumer(input int r);
    logic v, rd;
    logic [T-1:0] d, e;
    int sz;
    forever begin
      @(negedge clk);
      v = r ? m1_valid : m0_valid;
      rd = r ? m1_ready : m0_ready;
      d = r ? m1_data : m0_data;
      if (v && rd && !reset) begin
        ocnt[r]++;
        sz = r ? expq1.size() : expq0.size();
        if (sz == 0) chk($sformatf("m%0d_unexpected", r), sz, 1);
        else begin
          e = r ? expq1.pop_front() : expq0.pop_front();
          chk($sformatf("m%0d_data", r), d, e);
        end
      end
      if (r == 1 && forbid1) chk("m1_valid_idle", m1_valid, 0);
      @(posedge clk);
      #1;
      if (r == 1) m1_ready = $urandom_range(99) < rdy_pct[1];
      else m0_ready = $urandom_range(99) < rdy_pct[0];
    end
  endtask
  initial consumer(0);
  initial consumer(1);
  initial forever begin
    @(negedge clk);
    if (reset) icnt = '{0, 0};
    else begin
      if (s0_valid && s0_ready) begin
        if (icnt[0] % N == 0) glog.push_back(0);
        icnt[0]++;
      end
      if (s1_valid && s1_ready) begin
        if (icnt[1] % N == 0) glog.push_back(1);
        icnt[1]++;
      end
    end
  end
  task automatic drive(input int r, input logic v, input logic [T-1:0] d);
    if (r == 1) begin
      s1_valid = v;
      s1_data = d;
    end else begin
      s0_valid = v;
      s0_data = d;
    end
  endtask
  task automatic send_vec(input int r, input int vpct);
    vec_t v;
    logic hs;
    int c;
    for (int i = 0; i < N; i++) v[i] = T'($urandom);
    for (int j = 0; j < M; j++)
      if (r == 1) expq1.push_back(lfn(v, j));
      else expq0.push_back(lfn(v, j));
    for (int i = 0; i < N; i++) begin
      while ($urandom_range(99) >= vpct) begin
        drive(r, 1'b0, '0);
        @(posedge clk);
        #1;
      end
      drive(r, 1'b1, v[i]);
      c = 0;
      do begin
        @(negedge clk);
        hs = r ? s1_ready : s0_ready;
        @(posedge clk);
        #1;
        c++;
      end while (!hs && c < 5000);
      if (!hs) begin
        chk($sformatf("s%0d_timeout", r), c, 0);
        drive(r, 1'b0, '0);
        return;
      end
    end
    drive(r, 1'b0, '0);
  endtask
  task automatic drain();
    int c = 0;
    while ((expq0.size() + expq1.size()) > 0 && c < 20000) begin
      @(posedge clk);
      c++;
    end
    if (c >= 20000) chk("drain_timeout", c, 0);
    #1;
  endtask
  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    @(posedge clk);
    #1;
  endtask
  initial begin
    #950000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
  initial begin
    int k, c, b0, b1, c0;
    logic hs;
    reset = 1'b1;
    s0_valid = 1'b0;
    s1_valid = 1'b0;
    s0_data = '0;
    s1_data = '0;
    m0_ready = 1'b0;
    m1_ready = 1'b0;
    rdy_pct = '{100, 100};
    ocnt = '{0, 0};
    lrdy = 100;
    lvld = 100;
    forbid1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s0_ready", s0_ready, 0);
    chk("rst_s1_ready", s1_ready, 0);
    chk("rst_m0_valid", m0_valid, 0);
    chk("rst_m1_valid", m1_valid, 0);
    chk("rst_l_s_valid", l_s_valid, 0);
    chk("rst_l_m_ready", l_m_ready, 0);
    @(negedge clk);
    #2 reset = 1'b0;
    @(posedge clk);
    #1;
    s0_valid = 1'b1;
    s0_data = 16'h1000;
    k = 0;
    c = 0;
    while (k < 3 && c < 100) begin
      @(negedge clk);
      hs = s0_ready;
      @(posedge clk);
      #1;
      c++;
      if (hs) begin
        k++;
        s0_data = s0_data + 1'b1;
      end
    end
    chk("rst_pre_words", k, 3);
    @(negedge clk);
    chk("pre_rst_s0_ready", s0_ready, 1);
    #2 reset = 1'b1;
    #1;
    chk("async_s0_ready", s0_ready, 0);
    chk("async_l_s_valid", l_s_valid, 0);
    chk("async_m0_valid", m0_valid, 0);
    chk("async_l_m_ready", l_m_ready, 0);
    s0_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    @(posedge clk);
    #1;
    b0 = ocnt[0];
    send_vec(0, 100);
    drain();
    chk("rst_m0_count", ocnt[0] - b0, M);
    forbid1 = 1'b1;
    b0 = ocnt[0];
    b1 = icnt[0];
    c0 = cyc;
    repeat (4) send_vec(0, 100);
    chk("t2_cycles", cyc - c0, 4 * (N + 1));
    drain();
    forbid1 = 1'b0;
    chk("t2_in_hs", icnt[0] - b1, 4 * N);
    chk("t2_m0_count", ocnt[0] - b0, 4 * M);
    do_reset();
    glog.delete();
    fork
      repeat (4) send_vec(0, 100);
      repeat (4) send_vec(1, 100);
    join
    drain();
    chk("t3_grants", glog.size(), 8);
    for (int i = 0; i < glog.size(); i++) chk($sformatf("t3_grant%0d", i), glog[i], i % 2);
    rdy_pct[1] = 0;
    repeat (2) @(posedge clk);
    #2;
    b1 = ocnt[1];
    repeat (TD) send_vec(1, 100);
    fork
      send_vec(1, 100);
      send_vec(0, 100);
      begin
        repeat (40) begin
          @(negedge clk);
          chk("t4_s0_blocked", s0_ready, 0);
          chk("t4_s1_blocked", s1_ready, 0);
        end
        chk("t4_m1_stalled", ocnt[1] - b1, 0);
        rdy_pct[1] = 100;
      end
    join
    drain();
    chk("t4_m1_count", ocnt[1] - b1, (TD + 1) * M);
    rdy_pct = '{85, 85};
    lrdy = 85;
    lvld = 85;
    b0 = ocnt[0];
    b1 = ocnt[1];
    fork
      repeat (1250) send_vec(0, 80);
      repeat (1250) send_vec(1, 80);
    join
    drain();
    chk("t5_m0_count", ocnt[0] - b0, 7500);
    chk("t5_m1_count", ocnt[1] - b1, 7500);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
